// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - repeating serial pattern transmitter with gaps and abort
module seq_pattern_tx #(
    parameter int WIDTH = 5,
    parameter int REP_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [REP_W-1:0] rep_in,
    input  logic [GAP_W-1:0] gap_in,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_last,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pat_r, pat_n;
    logic [REP_W-1:0] rem_r, rem_n;
    logic [GAP_W-1:0] gap_r, gap_n;
    logic [GAP_W-1:0] gcnt_r, gcnt_n;
    logic [BW-1:0]    bit_r, bit_n;
    logic [BW-1:0]    idx_n;
    logic             dout_n, valid_n, last_n, done_n;
    logic             accept;

    assign start_ready = (state == IDLE) && !abort && !reset;
    assign accept      = start_valid && start_ready;

    always_comb begin
        state_n = state;
        pat_n   = pat_r;
        rem_n   = rem_r;
        gap_n   = gap_r;
        gcnt_n  = gcnt_r;
        bit_n   = bit_r;
        case (state)
            IDLE: begin
                if (accept) begin
                    pat_n  = pat_in;
                    gap_n  = gap_in;
                    bit_n  = '0;
                    gcnt_n = '0;
                    if (rep_in != '0) begin
                        state_n = SHIFT;
                        // rem counts emissions still owed after the current one
                        rem_n   = rep_in - 1'b1;
                    end else begin
                        state_n = DONE;
                        rem_n   = '0;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                    bit_n   = '0;
                    rem_n   = '0;
                end else if (bit_r == LAST_BIT) begin
                    bit_n = '0;
                    if (rem_r != '0) begin
                        rem_n = rem_r - 1'b1;
                        if (gap_r != '0) begin
                            state_n = GAP;
                            gcnt_n  = gap_r - 1'b1;
                        end
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    bit_n = bit_r + 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                    gcnt_n  = '0;
                    rem_n   = '0;
                end else if (gcnt_r == '0) begin
                    state_n = SHIFT;
                end else begin
                    gcnt_n = gcnt_r - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are precomputed from next-state values so they can be registered
    always_comb begin
        valid_n = (state_n == SHIFT);
        idx_n   = LAST_BIT - bit_n;
        dout_n  = valid_n & pat_n[idx_n];
        last_n  = valid_n && (bit_n == LAST_BIT);
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pat_r      <= '0;
            rem_r      <= '0;
            gap_r      <= '0;
            gcnt_r     <= '0;
            bit_r      <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            frame_last <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            pat_r      <= pat_n;
            rem_r      <= rem_n;
            gap_r      <= gap_n;
            gcnt_r     <= gcnt_n;
            bit_r      <= bit_n;
            dout       <= dout_n;
            dout_valid <= valid_n;
            frame_last <= last_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] pat_in;
    logic [3:0] rep_in;
    logic [2:0] gap_in;
    logic       start_valid;
    logic       start_ready;
    logic       abort;
    logic       dout;
    logic       dout_valid;
    logic       frame_last;
    logic       done;

    int checks   = 0;
    int failures = 0;

    seq_pattern_tx #(.WIDTH(5), .REP_W(4), .GAP_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .pat_in      (pat_in),
        .rep_in      (rep_in),
        .gap_in      (gap_in),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .abort       (abort),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_last  (frame_last),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {dout_valid, dout, frame_last, done};
    endfunction

    // Expected {valid, dout, last, done} for cycle c after accept
    function automatic logic [3:0] model(input logic [4:0] pat, input int rep, input int gap, input int c);
        int period, off, done_c;
        period = 5 + gap;
        off    = (c - 1) % period;
        done_c = (rep == 0) ? 1 : rep * 5 + (rep - 1) * gap + 1;
        model  = 4'b0000;
        if (c == done_c) begin
            model[0] = 1'b1;
        end else if (rep > 0 && c >= 1 && c < done_c && off < 5) begin
            model[3] = 1'b1;
            model[2] = pat[4 - off];
            model[1] = (off == 4);
        end
    endfunction

    task automatic run_tx(input string tag, input logic [4:0] pat, input int rep, input int gap);
        int done_c;
        done_c      = (rep == 0) ? 1 : rep * 5 + (rep - 1) * gap + 1;
        pat_in      = pat;
        rep_in      = 4'(rep);
        gap_in      = 3'(gap);
        start_valid = 1'b1;
        #1;
        chk({tag, "_ready_pre"}, 32'(start_ready), 32'd1);
        step();
        start_valid = 1'b0;
        pat_in      = ~pat;
        rep_in      = 4'd0;
        gap_in      = 3'd7;
        for (int c = 1; c <= done_c; c++) begin
            chk($sformatf("%s_c%0d", tag, c), 32'(outs()), 32'(model(pat, rep, gap, c)));
            if (c == 1) chk({tag, "_busy"}, 32'(start_ready), 32'd0);
            step();
        end
        chk({tag, "_idle_out"}, 32'(outs()), 32'd0);
        chk({tag, "_ready_post"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        pat_in      = 5'd0;
        rep_in      = 4'd0;
        gap_in      = 3'd0;
        start_valid = 1'b0;
        abort       = 1'b0;
        step();
        step();
        chk("reset_out", 32'(outs()), 32'd0);
        chk("reset_ready", 32'(start_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_ready", 32'(start_ready), 32'd1);

        run_tx("r1g0", 5'b10101, 1, 0);
        run_tx("r3g2", 5'b10101, 3, 2);
        run_tx("r2g0", 5'b10101, 2, 0);
        run_tx("r0", 5'b10101, 0, 3);
        run_tx("r15g0", 5'b11001, 15, 0);
        run_tx("r2g7", 5'b00110, 2, 7);

        // abort during bit 3 of the first emission
        pat_in = 5'b10101; rep_in = 4'd2; gap_in = 3'd0; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        chk("ab_c1", 32'(outs()), 32'b1100);
        step();
        chk("ab_c2", 32'(outs()), 32'b1000);
        step();
        chk("ab_c3", 32'(outs()), 32'b1100);
        abort = 1'b1;
        step();
        chk("ab_c4_out", 32'(outs()), 32'd0);
        start_valid = 1'b1;
        #1;
        chk("ab_idle_ready", 32'(start_ready), 32'd0);
        step();
        chk("ab_no_accept", 32'(outs()), 32'd0);
        start_valid = 1'b0;
        abort = 1'b0;
        #1;
        chk("ab_ready_fall", 32'(start_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("ab_quiet_%0d", i), 32'(outs()), 32'd0);
        end

        // abort while in DONE still lets the done pulse finish
        pat_in = 5'b11111; rep_in = 4'd1; gap_in = 3'd0; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        for (int c = 1; c <= 5; c++) step();
        chk("abd_c6", 32'(outs()), 32'b0001);
        abort = 1'b1;
        step();
        chk("abd_c7_out", 32'(outs()), 32'd0);
        chk("abd_c7_ready", 32'(start_ready), 32'd0);
        abort = 1'b0;
        #1;
        chk("abd_ready", 32'(start_ready), 32'd1);

        // reset mid-GAP with start_valid held high while busy
        pat_in = 5'b10011; rep_in = 4'd3; gap_in = 3'd4; start_valid = 1'b1;
        step();
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("rg_c%0d", c), 32'(outs()), 32'(model(5'b10011, 3, 4, c)));
            chk($sformatf("rg_busy_%0d", c), 32'(start_ready), 32'd0);
            if (c < 7) step();
        end
        reset = 1'b1;
        #1;
        chk("rg_async_out", 32'(outs()), 32'd0);
        chk("rg_async_ready", 32'(start_ready), 32'd0);
        step();
        chk("rg_hold_out", 32'(outs()), 32'd0);
        reset = 1'b0;
        run_tx("rg_fresh", 5'b01100, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("rg_noqueue_%0d", i), 32'(outs()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter: WIDTH, 5, pattern length in bits (2..16).
REQ-002 Parameter: REP_W, 4, width of repetition count.
REQ-003 Parameter: GAP_W, 3, width of inter-pattern gap count.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 pat_in  input  WIDTH  pattern to transmit, MSB first.
REQ-007 rep_in  input  REP_W  number of pattern emissions; 0 means none.
REQ-008 gap_in  input  GAP_W  idle cycles between consecutive emissions.
REQ-009 start_valid  input  1  request to start a transmission.
REQ-010 start_ready  output  1  block can accept a request.
REQ-011 abort  input  1  terminate the transmission in progress.
REQ-012 dout  output  1  serial data bit; intended to drive din of the team's serial sequence detectors.
REQ-013 dout_valid  output  1  dout carries a pattern bit this cycle.
REQ-014 frame_last  output  1  dout is the last bit of an emission.
REQ-015 done  output  1  one-cycle pulse at normal completion.

Function
REQ-016 States SHALL be IDLE, SHIFT, GAP, DONE.
REQ-017 start_ready SHALL equal (state==IDLE) && !abort && !reset, combinationally.
REQ-018 Accept on the rising edge with start_valid && start_ready; latch pat_in, rep_in, gap_in; ignore those inputs until the next accept.
REQ-019 On accept with rep_in!=0: go to SHIFT; the first bit pat_in[WIDTH-1] SHALL appear on dout with dout_valid=1 in the cycle after accept (latency 1).
REQ-020 On accept with rep_in==0: go to DONE; no dout_valid in any cycle.
REQ-021 SHIFT: one bit per cycle, MSB to LSB, exactly WIDTH cycles per emission; bit counter 0..WIDTH-1, reloads to 0 per emission, never wraps mid-emission.
REQ-022 frame_last=1 exactly in the cycle the LSB is driven (dout_valid=1).
REQ-023 After the LSB with emissions remaining and gap>0: GAP for exactly gap cycles, then SHIFT restarting at MSB.
REQ-024 After the LSB with emissions remaining and gap==0: next emission's MSB in the immediately following cycle, no idle cycle.
REQ-025 After the LSB of the final emission: DONE for one cycle with done=1, then IDLE.
REQ-026 dout, dout_valid, frame_last SHALL be registered; dout=0 whenever dout_valid=0.
REQ-027 start_valid while not IDLE SHALL have no effect and SHALL NOT be queued.
REQ-028 abort=1 in SHIFT or GAP: next state IDLE; dout_valid, frame_last, done all 0 from the next cycle; done SHALL NOT pulse.
REQ-029 abort=1 in DONE: done pulse still completes; then IDLE.
REQ-030 abort=1 in IDLE together with start_valid: request not accepted (start_ready=0).
REQ-031 Emission counter SHALL count rep_in emissions exactly, including rep_in = 2^REP_W-1, with no overflow.

Reset
REQ-032 While reset=1: state IDLE; dout, dout_valid, frame_last, done = 0; start_ready = 0; all counters 0.
REQ-033 Reset asserted mid-SHIFT or mid-GAP SHALL clear outputs immediately; no done pulse; first rising edge after release with start_valid=1 SHALL be accepted.

Verification
REQ-034 pat=5'b10101, rep=1, gap=0 -> cycles 1-5 after accept dout=1,0,1,0,1 valid; frame_last cycle 5; done cycle 6; start_ready=1 cycle 7.
REQ-035 pat=5'b10101, rep=3, gap=2 -> valid cycles 1-5, 8-12, 15-19; dout=0/valid=0 cycles 6-7, 13-14; frame_last at 5, 12, 19; done at 20.
REQ-036 pat=5'b10101, rep=2, gap=0 -> 10 consecutive valid bits 1010110101; frame_last at 5 and 10; done at 11.
REQ-037 rep=0 -> done at cycle 1 after accept, dout_valid never 1, start_ready=1 at cycle 2.
REQ-038 rep=2, abort during bit 3 of emission 1 -> dout_valid=0 next cycle, done never pulses, start_ready=1 once abort falls.
REQ-039 reset pulsed during GAP (rep=3, gap=4), also start_valid held high while busy -> outputs 0 immediately, no done, no queued request; fresh accept after release transmits normally.
